// File: rtl/scan_pkg.sv
// Shared types and sizing constants for the 4-digit display scan controller.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } scan_state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEL_W      = 2;

endpackage

// File: rtl/scan_tick_gen.sv
// Per-state cycle counter: counts up to a limit, flags terminal count, then restarts.
module scan_tick_gen #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == limit);

  // Terminal count always coincides with a state change, so it restarts the count too.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tc) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller with dead-time gaps and per-frame latching.
// Optional build macro LEADING_ZERO_BLANK_EN auto-blanks leading zero digits 3..1.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned GAP_CYC  = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blank_mask,
  output logic [1:0]  sel,
  output logic        sel_en,
  output logic [3:0]  digit_val,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] ACT_LIM = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  scan_state_e                          state_q, state_d;
  logic [SEL_W-1:0]                     sel_q, sel_d;
  logic [NUM_DIGITS*DIGIT_W-1:0]        frame_q, frame_d;
  logic [NUM_DIGITS-1:0]                mask_q, mask_d;
  logic                                 sel_en_q, sel_en_d;
  logic [DIGIT_W-1:0]                   digit_val_q, digit_val_d;
  logic                                 frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]                eff_mask;
  logic                                 tc;
  logic                                 cnt_clear;
  logic [CNT_W-1:0]                     cnt_limit;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  always_comb begin
    lz_mask    = '0;
    lz_mask[3] = (digits_in[15:12] == '0);
    lz_mask[2] = lz_mask[3] && (digits_in[11:8] == '0);
    lz_mask[1] = lz_mask[2] && (digits_in[7:4] == '0);
    eff_mask   = blank_mask | lz_mask;
  end
`else
  always_comb eff_mask = blank_mask;
`endif

  assign cnt_clear = !run || (state_q == IDLE);
  assign cnt_limit = (state_q == GAP) ? GAP_LIM : ACT_LIM;

  scan_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .limit (cnt_limit),
    .tc    (tc)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    frame_d       = frame_q;
    mask_d        = mask_q;
    frame_start_d = 1'b0;
    if (!run) begin
      state_d = IDLE;
      sel_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = ACTIVE;
          sel_d         = '0;
          frame_d       = digits_in;
          mask_d        = eff_mask;
          frame_start_d = 1'b1;
        end
        ACTIVE, GAP: begin
          if (tc) begin
            if (state_q == ACTIVE && GAP_CYC > 0) begin
              state_d = GAP;
            end else begin
              state_d = ACTIVE;
              sel_d   = sel_q + 1'b1;
              if (sel_q == SEL_W'(NUM_DIGITS - 1)) begin
                frame_d       = digits_in;
                mask_d        = eff_mask;
                frame_start_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
        end
      endcase
    end
    // Outputs are registered from next-state values so they line up with state_q.
    sel_en_d    = (state_d == ACTIVE) && !mask_d[sel_d];
    digit_val_d = frame_d[DIGIT_W*sel_d +: DIGIT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      frame_q       <= '0;
      mask_q        <= '0;
      sel_en_q      <= 1'b0;
      digit_val_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      frame_q       <= frame_d;
      mask_q        <= mask_d;
      sel_en_q      <= sel_en_d;
      digit_val_q   <= digit_val_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign sel         = sel_q;
  assign sel_en      = sel_en_q;
  assign digit_val   = digit_val_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: table vectors, corner sequences and a random run.
module tb_digit_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] digits_in;
  logic [3:0]  blank_mask;
  logic [1:0]  sel0, sel1;
  logic        en0, en1;
  logic [3:0]  dv0, dv1;
  logic        fs0, fs1;

  int checks = 0;
  int errors = 0;

  digit_scan_ctrl #(.TICK_DIV(4), .GAP_CYC(1), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .run(run), .digits_in(digits_in), .blank_mask(blank_mask),
    .sel(sel0), .sel_en(en0), .digit_val(dv0), .frame_start(fs0)
  );

  digit_scan_ctrl #(.TICK_DIV(4), .GAP_CYC(0), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .run(run), .digits_in(digits_in), .blank_mask(blank_mask),
    .sel(sel1), .sel_en(en1), .digit_val(dv1), .frame_start(fs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time offset inside the frame, plus the latched frame word and mask.
  bit          m_running [2];
  int          m_t       [2];
  logic [15:0] m_fr      [2];
  logic [3:0]  m_mk      [2];
  logic        m_fs      [2];
  int          m_per     [2];

  function automatic logic [3:0] eff_mask(input logic [15:0] d, input logic [3:0] m);
    logic [3:0] r;
    r = m;
`ifdef LEADING_ZERO_BLANK_EN
    if (d[15:12] == 0)                 r[3] = 1'b1;
    if (d[15:8] == 0)                  r[2] = 1'b1;
    if (d[15:4] == 0)                  r[1] = 1'b1;
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_running[i] = 0; m_t[i] = 0; m_fr[i] = '0; m_mk[i] = '0; m_fs[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_fs[i] = 1'b0;
      if (!run) begin
        m_running[i] = 0;
      end else if (!m_running[i]) begin
        m_running[i] = 1; m_t[i] = 0;
        m_fr[i] = digits_in; m_mk[i] = eff_mask(digits_in, blank_mask); m_fs[i] = 1'b1;
      end else begin
        m_t[i]++;
        if (m_t[i] == 4 * m_per[i]) begin
          m_t[i] = 0;
          m_fr[i] = digits_in; m_mk[i] = eff_mask(digits_in, blank_mask); m_fs[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_out(input int i, output logic [1:0] s, output logic e,
                           output logic [3:0] v, output logic f);
    int d;
    if (m_running[i]) begin
      d = m_t[i] / m_per[i];
      s = 2'(d);
      e = ((m_t[i] % m_per[i]) < 4) && !m_mk[i][d];
      v = m_fr[i][4*d +: 4];
    end else begin
      s = 2'd0; e = 1'b0; v = m_fr[i][3:0];
    end
    f = m_fs[i];
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    logic [1:0] s; logic e; logic [3:0] v; logic f;
    @(posedge clk);
    model_edge();
    #1;
    model_out(0, s, e, v, f);
    chk("m0_sel", 16'(sel0), 16'(s)); chk("m0_en", 16'(en0), 16'(e));
    chk("m0_dv", 16'(dv0), 16'(v));   chk("m0_fs", 16'(fs0), 16'(f));
    model_out(1, s, e, v, f);
    chk("m1_sel", 16'(sel1), 16'(s)); chk("m1_en", 16'(en1), 16'(e));
    chk("m1_dv", 16'(dv1), 16'(v));   chk("m1_fs", 16'(fs1), 16'(f));
  endtask

  typedef struct {
    logic        run;
    logic [15:0] dig;
    logic [3:0]  msk;
    logic [1:0]  sel;
    logic        en;
    logic [3:0]  dv;
    logic        fs;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [15:0] d, input logic [3:0] m,
                     input logic [1:0] s, input logic e, input logic [3:0] v, input logic f);
    vec_t x;
    x.run = r; x.dig = d; x.msk = m; x.sel = s; x.en = e; x.dv = v; x.fs = f;
    tbl.push_back(x);
  endtask

  initial begin
    logic [15:0] in_dig [3];
    logic [3:0]  in_msk [3];
    logic [15:0] fr_dig [3];
    logic [3:0]  fr_msk [3];
    logic [15:0] cur;
    m_per[0] = 5; m_per[1] = 4;

    // Frame f latches fr_*; inputs switch to in_* from digit 1 onward (mid-frame change).
    fr_dig = '{16'h4321, 16'h8765, 16'h4321};
    fr_msk = '{4'b0000, 4'b0100, 4'b0100};
    in_dig = '{16'h8765, 16'h4321, 16'h4321};
    in_msk = '{4'b0100, 4'b0100, 4'b0100};
    for (int k = 0; k < 10; k++) add(1'b0, 16'h4321, 4'b0000, 2'd0, 1'b0, 4'h0, 1'b0);
    for (int f = 0; f < 3; f++)
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < 5; c++) begin
          cur = fr_dig[f];
          add(1'b1, (d == 0) ? fr_dig[f] : in_dig[f], (d == 0) ? fr_msk[f] : in_msk[f],
              2'(d), (c < 4) && !fr_msk[f][d], cur[4*d +: 4], (d == 0) && (c == 0));
        end

    rst_n = 1'b0; run = 1'b0; digits_in = 16'h4321; blank_mask = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", 16'(sel0), 16'd0); chk("rst_en", 16'(en0), 16'd0);
    chk("rst_dv", 16'(dv0), 16'd0);   chk("rst_fs", 16'(fs0), 16'd0);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      run = tbl[k].run; digits_in = tbl[k].dig; blank_mask = tbl[k].msk;
      step();
      chk("tbl_sel", 16'(sel0), 16'(tbl[k].sel));
      chk("tbl_en",  16'(en0),  16'(tbl[k].en));
      chk("tbl_dv",  16'(dv0),  16'(tbl[k].dv));
      chk("tbl_fs",  16'(fs0),  16'(tbl[k].fs));
    end

    // Zero-gap build: drop run exactly on the sel 3 -> 0 wrap.
    run = 1'b0; step();
    run = 1'b1; digits_in = 16'h4321; blank_mask = '0; step();
    repeat (15) step();
    chk("g0_pre_sel", 16'(sel1), 16'd3);
    chk("g0_pre_en",  16'(en1),  16'd1);
    run = 1'b0; step();
    chk("g0_stop_sel", 16'(sel1), 16'd0);
    chk("g0_stop_en",  16'(en1),  16'd0);
    chk("g0_stop_fs",  16'(fs1),  16'd0);
    chk("g0_stop_dv",  16'(dv1),  16'h1);

    // Leading-zero blanking on 0050.
    digits_in = 16'h0050; blank_mask = '0; run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic exp_en;
      step();
`ifdef LEADING_ZERO_BLANK_EN
      exp_en = ((k % 5) < 4) && ((k / 5) < 2);
`else
      exp_en = ((k % 5) < 4);
`endif
      chk("lz_sel", 16'(sel0), 16'(k / 5));
      chk("lz_en",  16'(en0),  16'(exp_en));
    end

    // Asynchronous reset in the middle of an ACTIVE window.
    digits_in = 16'h9abc;
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_sel", 16'(sel0), 16'd0); chk("arst_en", 16'(en0), 16'd0);
    chk("arst_dv", 16'(dv0), 16'd0);   chk("arst_fs", 16'(fs0), 16'd0);
    chk("arst_en1", 16'(en1), 16'd0);  chk("arst_dv1", 16'(dv1), 16'd0);
    run = 1'b0;
    #1 rst_n = 1'b1;

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      run = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 3) == 0) digits_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) digits_in[15:4] = '0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
